// File: rtl/radio_channel_xbar.sv
// N-channel sample crossbar between radio front-end and datapath cores.
// Selections are staged in shadow registers and committed now or at a VITA time.
module radio_channel_xbar #(
    parameter int unsigned NUM_CHANNELS = 2,
    parameter logic [7:0]  SR_XBAR_BASE = 8'd200,
    parameter int unsigned SEL_W        = 8
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            set_stb,
    input  logic [7:0]                      set_addr,
    input  logic [31:0]                     set_data,
    input  logic [63:0]                     vita_time,
    input  logic [NUM_CHANNELS*32-1:0]      rx_in,
    input  logic [NUM_CHANNELS-1:0]         rx_in_stb,
    input  logic [NUM_CHANNELS*32-1:0]      tx_in,
    input  logic [NUM_CHANNELS-1:0]         tx_in_stb,
    output logic [NUM_CHANNELS*32-1:0]      rx_out,
    output logic [NUM_CHANNELS-1:0]         rx_out_stb,
    output logic [NUM_CHANNELS*32-1:0]      tx_out,
    output logic [NUM_CHANNELS*SEL_W-1:0]   active_rx_sel,
    output logic [NUM_CHANNELS*SEL_W-1:0]   active_tx_sel,
    output logic                            armed,
    output logic                            late,
    output logic                            sel_err
);
    localparam int unsigned      N         = NUM_CHANNELS;
    localparam logic [SEL_W-1:0] L_N       = SEL_W'(N);
    localparam logic [SEL_W-1:0] L_RX_ZERO = SEL_W'(2 * N);

    typedef enum logic {StIdle, StArmed} state_t;

    state_t             r_state;
    logic [SEL_W-1:0]   r_shadow_rx  [N];
    logic [SEL_W-1:0]   r_shadow_tx  [N];
    logic [SEL_W-1:0]   r_pending_rx [N];
    logic [SEL_W-1:0]   r_pending_tx [N];
    logic [SEL_W-1:0]   r_active_rx  [N];
    logic [SEL_W-1:0]   r_active_tx  [N];
    logic [63:0]        r_cmd_time;
    logic               r_late;
    logic               r_sel_err;
    logic [N*32-1:0]    r_rx_out;
    logic [N-1:0]       r_rx_out_stb;
    logic [N*32-1:0]    r_tx_out;

    logic               w_wr_rx, w_wr_tx, w_wr_thi, w_wr_tlo, w_wr_ctrl;
    logic [SEL_W-1:0]   w_idx, w_code;
    logic               w_rx_ok, w_tx_ok;
    logic               w_commit_now, w_commit_timed, w_clear, w_late_now, w_fire;
    logic [31:0]        w_rx_mux [N];
    logic [31:0]        w_tx_mux [N];
    logic [N-1:0]       w_rx_mux_stb;

    assign w_wr_rx   = set_stb && (set_addr == SR_XBAR_BASE);
    assign w_wr_tx   = set_stb && (set_addr == SR_XBAR_BASE + 8'd1);
    assign w_wr_thi  = set_stb && (set_addr == SR_XBAR_BASE + 8'd2);
    assign w_wr_tlo  = set_stb && (set_addr == SR_XBAR_BASE + 8'd3);
    assign w_wr_ctrl = set_stb && (set_addr == SR_XBAR_BASE + 8'd4);

    assign w_idx   = set_data[SEL_W-1:0];
    assign w_code  = set_data[8 +: SEL_W];
    assign w_rx_ok = (w_idx < L_N) && (w_code <= L_RX_ZERO);
    assign w_tx_ok = (w_idx < L_N) && (w_code <= L_N);

    assign w_commit_now   = w_wr_ctrl && set_data[0] && !set_data[1];
    assign w_commit_timed = w_wr_ctrl && set_data[0] && set_data[1];
    assign w_clear        = w_wr_ctrl && set_data[2];
    assign w_late_now     = w_commit_timed && (vita_time > r_cmd_time);
    assign w_fire         = (r_state == StArmed) && rx_in_stb[0] && (vita_time >= r_cmd_time);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= StIdle;
            r_cmd_time <= '0;
            r_late     <= 1'b0;
            r_sel_err  <= 1'b0;
            for (int k = 0; k < N; k++) begin
                r_shadow_rx[k]  <= SEL_W'(k);
                r_shadow_tx[k]  <= SEL_W'(k);
                r_pending_rx[k] <= SEL_W'(k);
                r_pending_tx[k] <= SEL_W'(k);
                r_active_rx[k]  <= SEL_W'(k);
                r_active_tx[k]  <= SEL_W'(k);
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (w_wr_rx && w_rx_ok && (w_idx == SEL_W'(k))) r_shadow_rx[k] <= w_code;
                if (w_wr_tx && w_tx_ok && (w_idx == SEL_W'(k))) r_shadow_tx[k] <= w_code;
            end
            if (w_wr_thi) r_cmd_time[63:32] <= set_data;
            if (w_wr_tlo) r_cmd_time[31:0]  <= set_data;

            // A control write outranks a pending timed fire in the same cycle.
            if (w_commit_now || w_late_now) begin
                r_active_rx <= r_shadow_rx;
                r_active_tx <= r_shadow_tx;
                r_state     <= StIdle;
            end else if (w_commit_timed) begin
                r_pending_rx <= r_shadow_rx;
                r_pending_tx <= r_shadow_tx;
                r_state      <= StArmed;
            end else if (w_fire) begin
                r_active_rx <= r_pending_rx;
                r_active_tx <= r_pending_tx;
                r_state     <= StIdle;
            end

            // Clear first so a coincident set wins.
            if (w_clear) begin
                r_late    <= 1'b0;
                r_sel_err <= 1'b0;
            end
            if (w_late_now) r_late <= 1'b1;
            if ((w_wr_rx && !w_rx_ok) || (w_wr_tx && !w_tx_ok)) r_sel_err <= 1'b1;
        end
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            w_rx_mux[k]     = '0;
            w_rx_mux_stb[k] = rx_in_stb[k];
            w_tx_mux[k]     = '0;
            for (int c = 0; c < N; c++) begin
                if (r_active_rx[k] == SEL_W'(c)) begin
                    w_rx_mux[k]     = rx_in[c*32 +: 32];
                    w_rx_mux_stb[k] = rx_in_stb[c];
                end
                if (r_active_rx[k] == SEL_W'(c + N)) begin
                    w_rx_mux[k]     = tx_in[c*32 +: 32];
                    w_rx_mux_stb[k] = tx_in_stb[c];
                end
                if (r_active_tx[k] == SEL_W'(c)) w_tx_mux[k] = tx_in[c*32 +: 32];
            end
            active_rx_sel[k*SEL_W +: SEL_W] = r_active_rx[k];
            active_tx_sel[k*SEL_W +: SEL_W] = r_active_tx[k];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_out     <= '0;
            r_rx_out_stb <= '0;
            r_tx_out     <= '0;
        end else begin
            r_rx_out_stb <= w_rx_mux_stb;
            for (int k = 0; k < N; k++) begin
                r_rx_out[k*32 +: 32] <= w_rx_mux[k];
                r_tx_out[k*32 +: 32] <= w_tx_mux[k];
            end
        end
    end

    assign rx_out     = r_rx_out;
    assign rx_out_stb = r_rx_out_stb;
    assign tx_out     = r_tx_out;
    assign armed      = (r_state == StArmed);
    assign late       = r_late;
    assign sel_err    = r_sel_err;
endmodule

// File: doc/radio_channel_xbar.md
Name: radio_channel_xbar

Overview:
- Parametrised N-channel sample crossbar between the radio front-end ports and the radio datapath cores. It generalises the fixed 1-bit rx/tx channel-swap registers.
- Any RX output can select any front-end RX input, any TX stream (calibration loopback) or zero.
- Any TX output can select any TX stream or mute.
- Selection changes are staged on the settings bus and committed immediately or at a VITA time, aligned to a sample strobe.

Parameters:
NUM_CHANNELS, 2, number of radio channels (1..16)
SR_XBAR_BASE, 8'd200, base settings-bus address of the five xbar registers
SEL_W, 8, width of a source code field (fixed; codes above the legal range are rejected)

Ports:
clk  input  1  ce clock
reset_n  input  1  asynchronous, active-low reset
set_stb  input  1  settings strobe (muxed bus)
set_addr  input  8  settings address
set_data  input  32  settings data
vita_time  input  64  current timekeeper time
rx_in  input  NUM_CHANNELS*32  front-end RX samples
rx_in_stb  input  NUM_CHANNELS  RX sample strobes
tx_in  input  NUM_CHANNELS*32  datapath TX samples
tx_in_stb  input  NUM_CHANNELS  TX sample strobes
rx_out  output  NUM_CHANNELS*32  to datapath RX
rx_out_stb  output  NUM_CHANNELS  RX strobes out
tx_out  output  NUM_CHANNELS*32  to front-end TX
active_rx_sel  output  NUM_CHANNELS*8  live RX selections
active_tx_sel  output  NUM_CHANNELS*8  live TX selections
armed  output  1  timed commit pending
late  output  1  sticky: timed commit time already passed
sel_err  output  1  sticky: illegal selection write

Behaviour:
- Registers (offsets from SR_XBAR_BASE):
  - +0 SEL_RX: data[7:0]=output index k, data[15:8]=code. Loads shadow_rx[k].
  - +1 SEL_TX: same layout; loads shadow_tx[k].
  - +2 TIME_HI: loads cmd_time[63:32].
  - +3 TIME_LO: loads cmd_time[31:0].
  - +4 CTRL: bit0 commit, bit1 timed, bit2 clear_late_err.
- RX codes: 0..N-1 = rx_in[c]; N..2N-1 = tx_in[c-N] (loopback); 2N = zero. TX codes: 0..N-1 = tx_in[c]; N = mute.
- Illegal writes: index >= N, or code above the range above. Shadow is unchanged and sel_err is set.
- Reset (asynchronous, reset_n=0):
  - shadow and active selections = identity (k -> k).
  - rx_out, tx_out, rx_out_stb = 0.
  - armed, late, sel_err = 0; cmd_time = 0; FSM = IDLE.
- Datapath: one-cycle registered latency.
  - rx_out[k] <= selected sample; rx_out_stb[k] <= strobe of the selected source. For zero, the strobe follows rx_in_stb[k].
  - tx_out[k] <= selected tx_in, or 0 when muted.
- FSM IDLE / ARMED:
  - Untimed commit (bit0=1, bit1=0): active <= shadow on the next edge, from any state. ARMED is cancelled.
  - Timed commit: snapshot shadow into pending_rx/pending_tx and go to ARMED.
    - If vita_time > cmd_time at commit, set late, apply immediately and stay IDLE.
  - ARMED -> IDLE: on the first cycle where rx_in_stb[0]=1 and vita_time >= cmd_time. Active <= pending on that edge; the sample after that edge uses the new routing.
  - Timed commit while ARMED: re-snapshot, stay ARMED with the new time.
  - SEL writes while ARMED change only shadow, never pending.
  - armed = (FSM == ARMED).
- clear_late_err (bit2): clears late and sel_err.
  - If clear and a new set occur in the same cycle, set wins.
  - bit2 may be combined with a commit in the same write.
- Simultaneous SEL write and commit in one cycle: impossible, since there is one settings write per cycle.
- vita_time wrap is not handled; comparison is unsigned 64-bit.
- Reset while ARMED: the pending commit is discarded.

Test Plan:
- Reset, N=2 -> active_rx_sel={1,0}, active_tx_sel={1,0}; rx_out=rx_in delayed 1 cycle; armed=0.
- Immediate swap:
  - SEL_RX k=0 code 1, SEL_RX k=1 code 0, CTRL=1.
  - rx_out[0] carries rx_in[1] two edges after the CTRL strobe.
- Loopback:
  - SEL_RX k=1 code 2, CTRL=1, tx_in[0]=32'hA5A5_0001 with tx_in_stb[0] pulses.
  - rx_out[1]=32'hA5A5_0001 and rx_out_stb[1] mirrors tx_in_stb[0] one cycle later.
- Timed commit:
  - TIME=1000, TX k=0 code 2 (mute), CTRL=3 at vita_time=900.
  - armed=1 until the first rx_in_stb[0] with vita_time>=1000; then tx_out[0]=0 and armed=0.
- Late commit at vita_time=2000 for TIME=1000 -> applied next edge; late=1; CTRL=4 clears it.
- Illegal write: SEL_RX code 5 with N=2, and index 3 -> sel_err=1, shadow unchanged.
- Assert reset_n while ARMED -> armed=0 and identity routing; the pending change is never applied.
